// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; a single-chunk adder still needs one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice shared by every RUN cycle.
module adder_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder: a + b + cin over WIDTH bits, CHUNK bits per clock.
// Define ADDER_SEQ_SUB_EN to add a 'sub' port selecting a - b.
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    adder_state_t     state;
    adder_state_t     state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] opa_sh;
    logic [WIDTH-1:0] opb_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             creg;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             accept;
    logic             last;

    // Subtraction is folded into the captured operands: a + ~b + 1
`ifdef ADDER_SEQ_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    adder_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x (opa[CHUNK-1:0]),
        .y (opb[CHUNK-1:0]),
        .ci(creg),
        .s (slice_s),
        .co(slice_co)
    );

    // New chunks enter at the top of psum so the LSB chunk ends up at bit 0
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign psum_nxt = slice_s;
            assign opa_sh   = '0;
            assign opb_sh   = '0;
        end else begin : g_multi
            assign psum_nxt = {slice_s, psum[WIDTH-1:CHUNK]};
            assign opa_sh   = {{CHUNK{1'b0}}, opa[WIDTH-1:CHUNK]};
            assign opb_sh   = {{CHUNK{1'b0}}, opb[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only move on the final RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            creg  <= 1'b0;
            psum  <= '0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            opa  <= a;
            opb  <= b_eff;
            creg <= c_eff;
            psum <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            opa  <= opa_sh;
            opb  <= opb_sh;
            creg <= slice_co;
            psum <= psum_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                sum   <= psum_nxt;
                carry <= slice_co;
            end
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Directed and randomised checks for adder_seq, including alternate WIDTH/CHUNK builds.
module tb_adder_seq;

    localparam int NCH = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       cin   = 1'b0;
    logic       sub   = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic       busy, done, carry;
    logic [7:0] sum;

    logic        xstart = 1'b0;
    logic        xcin   = 1'b0;
    logic        xsub   = 1'b0;
    logic [15:0] xa     = 16'h0000;
    logic [15:0] xb     = 16'h0000;
    logic        busy81, done81, carry81;
    logic        busy88, done88, carry88;
    logic        busy164, done164, carry164;
    logic [7:0]  sum81, sum88;
    logic [15:0] sum164;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_seq #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    adder_seq #(.WIDTH(8), .CHUNK(1)) dut81 (
        .clk(clk), .rst(rst), .start(xstart), .a(xa[7:0]), .b(xb[7:0]), .cin(xcin),
`ifdef ADDER_SEQ_SUB_EN
        .sub(xsub),
`endif
        .busy(busy81), .done(done81), .sum(sum81), .carry(carry81)
    );

    adder_seq #(.WIDTH(8), .CHUNK(8)) dut88 (
        .clk(clk), .rst(rst), .start(xstart), .a(xa[7:0]), .b(xb[7:0]), .cin(xcin),
`ifdef ADDER_SEQ_SUB_EN
        .sub(xsub),
`endif
        .busy(busy88), .done(done88), .sum(sum88), .carry(carry88)
    );

    adder_seq #(.WIDTH(16), .CHUNK(4)) dut164 (
        .clk(clk), .rst(rst), .start(xstart), .a(xa), .b(xb), .cin(xcin),
`ifdef ADDER_SEQ_SUB_EN
        .sub(xsub),
`endif
        .busy(busy164), .done(done164), .sum(sum164), .carry(carry164)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Launches one operation, then scrambles the inputs once it is accepted
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic vc, input logic vs);
        @(negedge clk);
        a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; cin = ~vc; sub = ~vs;
    endtask

    task automatic runAndCheck(input string tag, input logic [7:0] va, input logic [7:0] vb,
                               input logic vc, input logic vs,
                               input logic [7:0] esum, input logic ecarry);
        applyStimulus(va, vb, vc, vs);
        for (int i = 1; i <= NCH; i++) begin
            checkOutput({tag, ".busy"}, busy, 1);
            checkOutput({tag, ".early_done"}, done, 0);
            @(negedge clk);
        end
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".done_busy"}, busy, 0);
        checkOutput({tag, ".sum"}, sum, esum);
        checkOutput({tag, ".carry"}, carry, ecarry);
        @(negedge clk);
        checkOutput({tag, ".done_pulse"}, done, 0);
        sub = 1'b0;
    endtask

    logic [8:0]  expv;
    logic [7:0]  la, lb;
    logic        lc;
    int          lat, dcount;
    int          l81, l88, l164;
    logic [8:0]  r81, r88;
    logic [16:0] r164;
    logic [15:0] ta [4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h005A};
    logic [15:0] tb [4] = '{16'h0001, 16'h4321, 16'h8000, 16'h003C};
    logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.sum", sum, 8'h00);
        checkOutput("reset.carry", carry, 0);

        runAndCheck("ovf", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        runAndCheck("add5a", 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0);

        // Back-to-back with an ignored start during RUN
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.busy1", busy, 1);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.hold_prev", sum, 8'h97);
        @(negedge clk);
        checkOutput("b2b.busy4", busy, 1);
        @(negedge clk);
        checkOutput("b2b.done1", done, 1);
        checkOutput("b2b.sum1", sum, 8'h30);
        checkOutput("b2b.carry1", carry, 0);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF;
        checkOutput("b2b.rerun", busy, 1);
        checkOutput("b2b.hold6", sum, 8'h30);
        for (int i = 7; i <= 9; i++) begin
            @(negedge clk);
            checkOutput("b2b.hold", sum, 8'h30);
            checkOutput("b2b.nodone", done, 0);
        end
        @(negedge clk);
        checkOutput("b2b.done2", done, 1);
        checkOutput("b2b.sum2", sum, 8'h02);
        checkOutput("b2b.carry2", carry, 0);

        runAndCheck("ffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Asynchronous reset in the middle of RUN
        applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.sum", sum, 8'h00);
        checkOutput("arst.carry", carry, 0);
        checkOutput("arst.busy", busy, 0);
        checkOutput("arst.done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("arst.no_done", dcount, 0);
        checkOutput("arst.idle", busy, 0);
        runAndCheck("post_rst", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef ADDER_SEQ_SUB_EN
        runAndCheck("sub_lt", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0);
        runAndCheck("sub_ge", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1);
        runAndCheck("sub0", 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0);
`endif

        // Random back-to-back operations against a reference sum
        @(negedge clk);
        sub = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        expv = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            lat = 0;
            do begin
                @(negedge clk);
                start = 1'b0;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                lat++;
            end while (!done && lat < 20);
            checkOutput("rand.latency", lat, NCH + 1);
            checkOutput("rand.sum", sum, expv[7:0]);
            checkOutput("rand.carry", carry, expv[8]);
            if (k < 199) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                expv = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                start = 1'b1;
            end
        end

        // Alternate parameter sets driven in lockstep
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            xa = ta[v]; xb = tb[v]; xcin = tc[v]; xstart = 1'b1;
            r81  = {1'b0, ta[v][7:0]} + {1'b0, tb[v][7:0]} + {8'h00, tc[v]};
            r88  = r81;
            r164 = {1'b0, ta[v]} + {1'b0, tb[v]} + {16'h0000, tc[v]};
            @(negedge clk);
            xstart = 1'b0; xa = ~ta[v]; xb = ~tb[v]; xcin = ~tc[v];
            l81 = 0; l88 = 0; l164 = 0;
            for (int c = 1; c <= 12; c++) begin
                if (done81 && l81 == 0) begin
                    l81 = c;
                    checkOutput("p81.sum", {carry81, sum81}, r81);
                end
                if (done88 && l88 == 0) begin
                    l88 = c;
                    checkOutput("p88.sum", {carry88, sum88}, r88);
                end
                if (done164 && l164 == 0) begin
                    l164 = c;
                    checkOutput("p164.sum", {carry164, sum164}, r164);
                end
                @(negedge clk);
            end
            checkOutput("p81.latency", l81, 9);
            checkOutput("p88.latency", l88, 2);
            checkOutput("p164.latency", l164, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised multi-cycle adder.
- Computes a + b + cin over WIDTH bits, processing CHUNK bits per clock through one shared CHUNK-bit adder slice.
- Operands are captured on a start/busy/done handshake.
- Area-lean replacement for wide single-cycle adders in datapaths that tolerate WIDTH/CHUNK+1 cycles of latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per RUN cycle; 1 gives a bit-serial adder, WIDTH gives a single RUN cycle.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and carry are valid from this cycle.
- sum  output  WIDTH  result register; holds last completed result.
- carry  output  1  carry-out of last completed result.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, sum and carry all 0; internal operand, partial-sum and chunk-count registers 0.
- NCHUNK = WIDTH/CHUNK. Chunk counter width is clog2(NCHUNK), minimum 1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a, b, cin; cnt=0; go to RUN. Otherwise stay.
  - RUN: add chunk cnt (LSB chunk first) of A and B plus the carry register. Write the CHUNK-bit result into the partial-sum register, LSB chunk first via right shift. Update the carry register; cnt++. After processing chunk NCHUNK-1, go to DONE.
  - DONE: sum and carry are loaded with the final values on the RUN->DONE edge. done=1 and busy=0 for exactly this cycle. If start=1, latch new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: if start is high in cycle 0 from IDLE, done is high in cycle NCHUNK+1. Throughput is one result per NCHUNK+1 cycles.
- start while busy: ignored; operands are not re-latched.
- sum and carry change only on the RUN->DONE edge. They hold the previous result during RUN and after DONE.
- Arithmetic: {carry,sum} = a + b + cin, exact (WIDTH+1)-bit result, no saturation. Overflow of an all-ones operand wraps sum and sets carry.
- Changes on a, b and cin after acceptance have no effect on the in-flight operation.
- Reset mid-RUN: immediate abort to IDLE; all outputs 0; no done pulse. The next start operates normally.
- CHUNK==WIDTH: RUN lasts one cycle; latency is 2.

Optional Feature:
- Macro: ADDER_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), captured with the operands on start.
  - sub=1 computes a - b as a + ~b + 1. cin is ignored; carry=1 means no borrow (a >= b unsigned).
  - sub=0 behaves identically to the undefined build.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package adder_pkg:
  - state enum type adder_state_t (IDLE, RUN, DONE);
  - function nchunk(WIDTH, CHUNK);
  - function cnt_width(n) returning clog2, minimum 1.
- One sub-module adder_chunk, parametrised by CHUNK: combinational CHUNK-bit slice with inputs x, y, ci and outputs s, co.
- The FSM, counter, operand shift registers and result registers stay in adder_seq.

Test Plan (WIDTH=8, CHUNK=2, NCHUNK=4, latency 5):
- Reset then idle 3 cycles -> busy=0, done=0, sum=8'h00, carry=0. Asserting rst asynchronously between edges clears outputs without waiting for clk.
- a=8'hFF, b=8'h01, cin=0, start pulse in cycle 0 -> busy high in cycles 1–4; done high only in cycle 5; sum=8'h00, carry=1. a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, carry=0.
- Start a=8'h10, b=8'h20. Re-pulse start with a=8'hFF, b=8'hFF during RUN, then start a=8'h01, b=8'h01 in the DONE cycle:
  - first result sum=8'h30, carry=0 (second start ignored);
  - next done arrives 5 cycles later with sum=8'h02;
  - sum holds 8'h30 in between.
- Assert rst in cycle 2 of a RUN -> outputs 0, no done pulse. A subsequent start of a=8'h80, b=8'h80 gives sum=8'h00, carry=1.
- ADDER_SEQ_SUB_EN build:
  - sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, carry=0;
  - sub=1, a=8'h20, b=8'h10 -> sum=8'h10, carry=1;
  - sub=0 matches the add results above.
- 200 random {a,b,cin} back-to-back operations, plus parameter sets (8,1), (8,8) and (16,4) -> every done cycle matches the reference model {carry,sum}=a+b+cin, and done-to-start latency is NCHUNK+1.
